// File: rtl/ula_pkg.sv
// ula_pkg: shared types for the MIPS ALU.
// Opcode encoding and the status-flag bundle.
package ula_pkg;

    typedef enum logic [2:0] {
        OP_AND = 3'b000,
        OP_OR  = 3'b001,
        OP_ADD = 3'b010,
        OP_XOR = 3'b011,
        OP_NOR = 3'b100,
        OP_SLL = 3'b101,
        OP_SUB = 3'b110,
        OP_SLT = 3'b111
    } op_t;

    typedef struct packed {
        logic zero;
        logic carry;
        logic overflow;
        logic negative;
    } flags_t;

    localparam flags_t FLAGS_RESET = '{
        zero: 1'b1,
        carry: 1'b0,
        overflow: 1'b0,
        negative: 1'b0
    };

endpackage

// File: rtl/ula_addsub.sv
// ula_addsub: shared adder/subtractor for ADD, SUB and SLT.
// Subtraction is A + ~B + 1, so carry=1 means no borrow.
module ula_addsub #(
    parameter int WIDTH = 16
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             sub,
    output logic [WIDTH-1:0] sum,
    output logic             carry,
    output logic             overflow
);

    logic [WIDTH-1:0] b_eff;
    logic [WIDTH:0]   full;

    assign b_eff = sub ? ~b : b;
    assign full  = {1'b0, a} + {1'b0, b_eff}
                 + {{WIDTH{1'b0}}, sub};
    assign sum   = full[WIDTH-1:0];
    assign carry = full[WIDTH];

    // Operands agree in sign (after inversion) but the sum does not.
    assign overflow = (a[WIDTH-1] == b_eff[WIDTH-1])
                    && (sum[WIDTH-1] != a[WIDTH-1]);

endmodule

// File: rtl/ula_unit.sv
// ula_unit: registered 3-bit-opcode MIPS ALU.
// One-cycle latency, one operation accepted per cycle.
module ula_unit
    import ula_pkg::*;
#(
    parameter int WIDTH   = 16,
    parameter int SHAMT_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] entrada1,
    input  logic [WIDTH-1:0] regA,
    input  logic [2:0]       op_select,
    input  logic             in_valid,
    output logic [WIDTH-1:0] saida_ula,
    output logic             out_valid,
    output logic             zero,
    output logic             carry,
    output logic             overflow,
    output logic             negative
);

    op_t              op;
    logic             as_sub;
    logic [WIDTH-1:0] as_sum;
    logic             as_carry;
    logic             as_ovf;
    logic [WIDTH-1:0] res_d;
    flags_t           flags_d;
    logic [WIDTH-1:0] res_q;
    flags_t           flags_q;
    logic             valid_q;

    assign op     = op_t'(op_select);
    assign as_sub = (op == OP_SUB) || (op == OP_SLT);

    ula_addsub #(
        .WIDTH(WIDTH)
    ) u_addsub (
        .a        (entrada1),
        .b        (regA),
        .sub      (as_sub),
        .sum      (as_sum),
        .carry    (as_carry),
        .overflow (as_ovf)
    );

    // Select the result and arithmetic flags for the current opcode.
    always_comb begin
        res_d            = '0;
        flags_d.carry    = 1'b0;
        flags_d.overflow = 1'b0;
        case (op)
            OP_AND: res_d = entrada1 & regA;
            OP_OR:  res_d = entrada1 | regA;
            OP_XOR: res_d = entrada1 ^ regA;
            OP_NOR: res_d = ~(entrada1 | regA);
            OP_SLL: res_d = entrada1 << regA[SHAMT_W-1:0];
            OP_ADD, OP_SUB: begin
                res_d            = as_sum;
                flags_d.carry    = as_carry;
                flags_d.overflow = as_ovf;
            end
            OP_SLT: begin
                res_d = {{(WIDTH-1){1'b0}},
                         as_sum[WIDTH-1] ^ as_ovf};
            end
            default: res_d = '0;
        endcase
        flags_d.zero     = (res_d == '0);
        flags_d.negative = res_d[WIDTH-1];
    end

    // Capture on valid, hold otherwise; reset wins over in_valid.
    always_ff @(posedge clk) begin
        if (rst) begin
            res_q   <= '0;
            flags_q <= FLAGS_RESET;
            valid_q <= 1'b0;
        end else begin
            valid_q <= in_valid;
            if (in_valid) begin
                res_q   <= res_d;
                flags_q <= flags_d;
            end
        end
    end

    assign saida_ula = res_q;
    assign out_valid = valid_q;
    assign zero      = flags_q.zero;
    assign carry     = flags_q.carry;
    assign overflow  = flags_q.overflow;
    assign negative  = flags_q.negative;

endmodule

// File: tb/tb_ula_unit.sv
// tb_ula_unit: scoreboard bench for ula_unit.
// Directed vectors push expectations; a monitor pops on out_valid.
module tb_ula_unit;

    logic        clk;
    logic        rst;
    logic [15:0] entrada1;
    logic [15:0] regA;
    logic [2:0]  op_select;
    logic        in_valid;
    logic [15:0] saida_ula;
    logic        out_valid;
    logic        zero;
    logic        carry;
    logic        overflow;
    logic        negative;

    typedef struct {
        string       name;
        logic [15:0] res;
        logic        z;
        logic        c;
        logic        v;
        logic        n;
    } exp_t;

    exp_t q[$];
    int   checks = 0;
    int   errors = 0;
    int   pushed = 0;
    int   popped = 0;

    ula_unit #(
        .WIDTH(16),
        .SHAMT_W(4)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .entrada1  (entrada1),
        .regA      (regA),
        .op_select (op_select),
        .in_valid  (in_valid),
        .saida_ula (saida_ula),
        .out_valid (out_valid),
        .zero      (zero),
        .carry     (carry),
        .overflow  (overflow),
        .negative  (negative)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1, "watchdog");
    end

    // Monitor: compare every presented output with the queue head.
    always @(negedge clk) begin
        if (out_valid) begin
            checks++;
            if (q.size() == 0) begin
                errors++;
                $display("FAIL unexpected: out_valid with empty queue res=%h",
                         saida_ula);
            end else begin
                exp_t e;
                e = q.pop_front();
                popped++;
                if ({saida_ula, zero, carry, overflow, negative}
                    !== {e.res, e.z, e.c, e.v, e.n}) begin
                    errors++;
                    $display("FAIL %s: got res=%h z%b c%b v%b n%b want res=%h z%b c%b v%b n%b",
                             e.name, saida_ula, zero, carry, overflow,
                             negative, e.res, e.z, e.c, e.v, e.n);
                end
            end
        end
    end

    task automatic issue(input string nm, input logic [2:0] op,
                         input logic [15:0] a, input logic [15:0] b,
                         input logic [15:0] r, input logic z,
                         input logic c, input logic v, input logic n);
        exp_t e;
        entrada1  = a;
        regA      = b;
        op_select = op;
        in_valid  = 1'b1;
        e = '{name: nm, res: r, z: z, c: c, v: v, n: n};
        q.push_back(e);
        pushed++;
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        in_valid = 1'b0;
        @(posedge clk);
        #1;
    endtask

    task automatic check_state(input string nm, input logic [15:0] r,
                               input logic ov, input logic z,
                               input logic c, input logic v,
                               input logic n);
        checks++;
        if ({saida_ula, out_valid, zero, carry, overflow, negative}
            !== {r, ov, z, c, v, n}) begin
            errors++;
            $display("FAIL %s: got res=%h ov%b z%b c%b v%b n%b want res=%h ov%b z%b c%b v%b n%b",
                     nm, saida_ula, out_valid, zero, carry, overflow,
                     negative, r, ov, z, c, v, n);
        end
    endtask

    initial begin
        rst       = 1'b1;
        in_valid  = 1'b0;
        entrada1  = '0;
        regA      = '0;
        op_select = '0;
        @(posedge clk);
        @(posedge clk);
        #1;
        check_state("reset", 16'h0000, 0, 1, 0, 0, 0);
        rst = 1'b0;

        // Back-to-back logic ops, A=8 B=9.
        issue("and", 3'b000, 16'h0008, 16'h0009, 16'h0008, 0, 0, 0, 0);
        issue("or",  3'b001, 16'h0008, 16'h0009, 16'h0009, 0, 0, 0, 0);
        issue("xor", 3'b011, 16'h0008, 16'h0009, 16'h0001, 0, 0, 0, 0);
        issue("nor", 3'b100, 16'h0008, 16'h0009, 16'hFFF6, 0, 0, 0, 1);

        // Shift / compare / arithmetic, A=8 B=9.
        issue("sll", 3'b101, 16'h0008, 16'h0009, 16'h1000, 0, 0, 0, 0);
        issue("slt", 3'b111, 16'h0008, 16'h0009, 16'h0001, 0, 0, 0, 0);
        issue("add", 3'b010, 16'h0008, 16'h0009, 16'h0011, 0, 0, 0, 0);
        issue("sub", 3'b110, 16'h0008, 16'h0009, 16'hFFFF, 0, 0, 0, 1);

        // Corners.
        issue("add_ovf", 3'b010, 16'h7FFF, 16'h0001,
              16'h8000, 0, 0, 1, 1);
        issue("add_carry", 3'b010, 16'hFFFF, 16'h0001,
              16'h0000, 1, 1, 0, 0);
        issue("sub_ovf", 3'b110, 16'h8000, 16'h0001,
              16'h7FFF, 0, 1, 1, 0);
        issue("slt_neg", 3'b111, 16'h8000, 16'h0001,
              16'h0001, 0, 0, 0, 0);
        issue("slt_false", 3'b111, 16'h0009, 16'h0008,
              16'h0000, 1, 0, 0, 0);
        issue("sub_noborrow", 3'b110, 16'h0009, 16'h0008,
              16'h0001, 0, 1, 0, 0);
        issue("sll_15", 3'b101, 16'h0001, 16'h000F,
              16'h8000, 0, 0, 0, 1);
        issue("sll_wrap", 3'b101, 16'h0001, 16'h0010,
              16'h0001, 0, 0, 0, 0);

        // Hold after ADD.
        issue("add_hold", 3'b010, 16'h0008, 16'h0009,
              16'h0011, 0, 0, 0, 0);
        idle();
        check_state("hold1", 16'h0011, 0, 0, 0, 0, 0);
        entrada1  = 16'hFFFF;
        regA      = 16'h0001;
        idle();
        check_state("hold2", 16'h0011, 0, 0, 0, 0, 0);

        // Reset together with a valid op drops it.
        issue("pre_rst", 3'b010, 16'hFFFF, 16'h0001,
              16'h0000, 1, 1, 0, 0);
        rst       = 1'b1;
        in_valid  = 1'b1;
        op_select = 3'b010;
        entrada1  = 16'h7FFF;
        regA      = 16'h0001;
        @(posedge clk);
        #1;
        check_state("rst_drop", 16'h0000, 0, 1, 0, 0, 0);
        rst      = 1'b0;
        in_valid = 1'b0;
        idle();
        check_state("rst_after", 16'h0000, 0, 1, 0, 0, 0);

        issue("post_rst", 3'b110, 16'h0008, 16'h0009,
              16'hFFFF, 0, 0, 0, 1);
        idle();
        idle();

        checks++;
        if (q.size() != 0 || popped != pushed) begin
            errors++;
            $display("FAIL drain: popped=%0d pushed=%0d left=%0d",
                     popped, pushed, q.size());
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/ula_unit.md
Name: ula_unit

Overview:
- Registered 3-bit-opcode arithmetic/logic unit for the MIPS datapath; MIPS ALU-control encoding.
- Two WIDTH-bit operands in; one WIDTH-bit result plus status flags out, one clock later.
- Sits between the register-file/immediate mux (operands) and the writeback/branch logic (result, zero flag).

Parameters:
- WIDTH, 16, operand/result width; must be >= 8; the datapath instantiates it at 32.
- SHAMT_W, 4, shift-amount bits taken from regA; must equal log2(WIDTH) (5 at WIDTH=32).

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- entrada1  in  WIDTH  operand A.
- regA  in  WIDTH  operand B; low SHAMT_W bits are the shift amount.
- op_select  in  3  operation code, see Behaviour.
- in_valid  in  1  operands/opcode valid this cycle.
- saida_ula  out  WIDTH  registered result.
- out_valid  out  1  saida_ula/flags valid (in_valid delayed by 1).
- zero  out  1  registered result == 0.
- carry  out  1  carry-out of ADD/SUB adder; 0 for other ops.
- overflow  out  1  signed overflow of ADD/SUB; 0 for other ops.
- negative  out  1  result MSB.

Behaviour:
- Opcodes (A = entrada1, B = regA):
  - 000 AND: A & B.
  - 001 OR: A | B.
  - 010 ADD: A + B; carry = bit WIDTH of the sum.
  - 011 XOR: A ^ B.
  - 100 NOR: ~(A | B).
  - 101 SLL: A << B[SHAMT_W-1:0]; zero fill.
  - 110 SUB: A + ~B + 1; carry = 1 means no borrow (A >= B unsigned).
  - 111 SLT: result = {0..., (A < B) signed}; compute from sign of the subtraction XOR overflow; carry/overflow outputs forced 0.
- Overflow, ADD: A and B have the same sign and the sum sign differs.
- Overflow, SUB: A and B have different signs and the result sign differs from A.
- Latency: exactly 1 cycle. When in_valid=1 at edge N, results appear after edge N with out_valid=1.
- When in_valid=0: saida_ula and all flags hold their previous values; out_valid=0.
- Reset (rst=1 at an edge): saida_ula=0, out_valid=0, carry=0, overflow=0, negative=0, zero=1.
- Reset dominates in_valid in the same cycle.
- Reset mid-stream discards the in-flight operation.
- Fully pipelined: a new operation is accepted every cycle; no backpressure.
- All arithmetic is modulo 2^WIDTH; no saturation.

Decomposition:
- Shared package ula_pkg holds:
  - the opcode enum (OP_AND=3'b000, OP_OR=3'b001, OP_ADD=3'b010, OP_XOR=3'b011, OP_NOR=3'b100, OP_SLL=3'b101, OP_SUB=3'b110, OP_SLT=3'b111);
  - the flag struct (zero, carry, overflow, negative).
- One natural combinational sub-module: ula_addsub. It takes A, B and a sub flag and returns sum, carry and overflow; it is shared by ADD, SUB and SLT.
- The top level holds the logic/shift mux and the output registers.

Test Plan:
- Reset: rst=1 for 2 cycles -> saida_ula=0, zero=1, out_valid=0, carry=0, overflow=0, negative=0.
- Logic ops, A=16'h0008, B=16'h0009, issued back-to-back one per cycle -> out_valid=1 every cycle, each result 1 cycle later:
  - AND = 16'h0008
  - OR = 16'h0009
  - XOR = 16'h0001
  - NOR = 16'hFFF6 (negative=1)
- Shift/compare, A=8, B=9:
  - SLL -> 16'h1000
  - SLT -> 16'h0001
  - ADD -> 16'h0011, carry=0, overflow=0
  - SUB -> 16'hFFFF, carry=0, negative=1
- Overflow/carry corners:
  - ADD 16'h7FFF+16'h0001 -> 16'h8000, overflow=1, carry=0
  - ADD 16'hFFFF+16'h0001 -> 16'h0000, carry=1, zero=1, overflow=0
  - SUB 16'h8000-16'h0001 -> 16'h7FFF, overflow=1
  - SLT A=16'h8000, B=16'h0001 -> 16'h0001
- Hold/reset interaction:
  - in_valid=0 after an ADD -> outputs hold the ADD result with out_valid=0.
  - rst=1 together with in_valid=1 -> reset values; the operation is dropped.
